sr_cmd_gen: RTL and testbench

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

---
 rtl/sr_cmd_gen.sv | 137 +++++++++++++
 tb/tb_sr_cmd_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// Debounced two-button command generator driving a downstream SR flip-flop.
// Each accepted press becomes one registered s or r pulse; clear has priority over set.
module sr_cmd_gen #(
  parameter int unsigned DB_LEN  = 4,
  parameter int unsigned GAP_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic clr_btn,
  input  logic en,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int unsigned ChSet = 0;
  localparam int unsigned ChClr = 1;

  localparam logic [7:0] DbMax  = 8'(DB_LEN - 1);
  localparam logic [7:0] GapMax = 8'(GAP_LEN - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEmit = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      db_rise;
  logic [1:0]      pend_q, pend_d, pend_clr;

  logic [1:0] state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       busy_q, busy_d;
  logic       conflict_q, conflict_d;

  assign btn_raw = {clr_btn, set_btn};

  // A level change is accepted only after DB_LEN consecutive cycles that disagree with db.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    db_rise = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DbMax) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
      db_rise[i] = ~db_q[i] & db_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    conflict_d = 1'b0;
    pend_clr   = 2'b00;
    case (state_q)
      StIdle: begin
        if (pend_q[ChClr]) begin
          state_d    = StEmit;
          r_d        = 1'b1;
          conflict_d = pend_q[ChSet];
          pend_clr   = 2'b11;
        end else if (pend_q[ChSet]) begin
          state_d  = StEmit;
          s_d      = 1'b1;
          pend_clr = 2'b01;
        end
      end
      StEmit: begin
        state_d = StGap;
        gap_d   = 8'd0;
      end
      StGap: begin
        if (gap_q == GapMax) begin
          state_d = StIdle;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = 8'd0;
      end
    endcase
    // A rise landing on the same edge that consumes a request stays pending.
    pend_d = (pend_q & ~pend_clr) | (db_rise & {2{en}});
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      state_q    <= StIdle;
      gap_q      <= 8'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed bench for sr_cmd_gen with DB_LEN=4, GAP_LEN=3.
// Edge n below means the n-th rising clock edge after a raw button change.
module tb_sr_cmd_gen;

  logic clk = 1'b0;
  logic reset;
  logic set_btn, clr_btn, en;
  logic s, r, busy, conflict;

  int checks = 0;
  int errors = 0;

  sr_cmd_gen #(
    .DB_LEN (4),
    .GAP_LEN(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set_btn (set_btn),
    .clr_btn (clr_btn),
    .en      (en),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts cycles in which each output is high over the next n edges.
  task automatic run_count(input int n, output int ns, output int nr, output int nc,
                           output int nb, output int nsr);
    ns = 0; nr = 0; nc = 0; nb = 0; nsr = 0;
    repeat (n) begin
      tick(1);
      if (s === 1'b1) ns++;
      if (r === 1'b1) nr++;
      if (conflict === 1'b1) nc++;
      if (busy === 1'b1) nb++;
      if (s === 1'b1 && r === 1'b1) nsr++;
    end
  endtask

  initial begin
    int ns, nr, nc, nb, nsr;
    reset   = 1'b1;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    en      = 1'b1;
    tick(2);
    check("reset_s", s, 1'b0);
    check("reset_r", r, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_conflict", conflict, 1'b0);
    reset = 1'b0;
    tick(3);

    // Single set press; en dropped mid-GAP must not abort it.
    set_btn = 1'b1;
    tick(6);
    check("set_e6_s", s, 1'b0);
    check("set_e6_busy", busy, 1'b0);
    tick(1);
    check("set_e7_s", s, 1'b1);
    check("set_e7_busy", busy, 1'b1);
    check("set_e7_r", r, 1'b0);
    en = 1'b0;
    tick(1);
    check("set_e8_s", s, 1'b0);
    check("set_e8_busy", busy, 1'b1);
    tick(2);
    check("set_e10_busy", busy, 1'b1);
    tick(1);
    check("set_e11_busy", busy, 1'b0);
    en = 1'b1;
    set_btn = 1'b0;
    run_count(12, ns, nr, nc, nb, nsr);
    check("release_no_s", ns, 0);
    check("release_no_r", nr, 0);

    // Pulse of 3 synchronized cycles is rejected.
    set_btn = 1'b1;
    tick(3);
    set_btn = 1'b0;
    run_count(15, ns, nr, nc, nb, nsr);
    check("short_pulse_s", ns, 0);
    check("short_pulse_r", nr, 0);

    // Pulse of exactly 4 synchronized cycles is accepted.
    set_btn = 1'b1;
    tick(4);
    set_btn = 1'b0;
    run_count(20, ns, nr, nc, nb, nsr);
    check("min_pulse_s", ns, 1);
    check("min_pulse_busy", nb, 4);

    // Simultaneous press: clear wins, conflict flags the dropped set.
    set_btn = 1'b1;
    clr_btn = 1'b1;
    tick(6);
    check("both_e6_r", r, 1'b0);
    tick(1);
    check("both_e7_r", r, 1'b1);
    check("both_e7_conflict", conflict, 1'b1);
    check("both_e7_s", s, 1'b0);
    run_count(20, ns, nr, nc, nb, nsr);
    check("both_after_s", ns, 0);
    check("both_after_r", nr, 0);
    check("both_after_conflict", nc, 0);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tick(12);

    // Clear accepted during GAP is issued after returning to IDLE.
    set_btn = 1'b1;
    tick(3);
    clr_btn = 1'b1;
    tick(4);
    check("gap_e7_s", s, 1'b1);
    check("gap_e7_r", r, 1'b0);
    tick(4);
    check("gap_e11_busy", busy, 1'b0);
    check("gap_e11_r", r, 1'b0);
    tick(1);
    check("gap_e12_r", r, 1'b1);
    check("gap_e12_s", s, 1'b0);
    check("gap_e12_conflict", conflict, 1'b0);
    check("gap_e12_busy", busy, 1'b1);
    tick(1);
    check("gap_e13_r", r, 1'b0);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    run_count(12, ns, nr, nc, nb, nsr);
    check("gap_tail_s", ns, 0);
    check("gap_tail_r", nr, 0);

    // Rise settling with en=0 never becomes a command.
    en = 1'b0;
    set_btn = 1'b1;
    tick(10);
    en = 1'b1;
    run_count(20, ns, nr, nc, nb, nsr);
    check("en_low_s", ns, 0);
    check("en_low_busy", nb, 0);
    set_btn = 1'b0;
    tick(12);

    // Asynchronous reset during EMIT.
    set_btn = 1'b1;
    tick(7);
    check("rst_pre_s", s, 1'b1);
    #2;
    reset   = 1'b1;
    set_btn = 1'b0;
    #1;
    check("rst_async_s", s, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    tick(2);
    reset = 1'b0;
    run_count(25, ns, nr, nc, nb, nsr);
    check("rst_after_s", ns, 0);
    check("rst_after_r", nr, 0);
    check("rst_after_busy", nb, 0);
    check("overlap_sr", nsr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
